debug_monitor: RTL and testbench

DEBUG_MONITOR -- requirements
Module: debug_monitor

---
 rtl/debug_monitor_pkg.sv | 35 +++
 rtl/debug_monitor_rise.sv | 19 +
 rtl/debug_monitor.sv | 123 ++++++++++++
 tb/tb_debug_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_monitor_pkg.sv
// Shared types and helpers for the debug channel monitor.
// The next-channel search is written for the largest legal channel count and narrowed by the caller.
package debug_monitor_pkg;

   localparam int MAX_NCH  = 16;
   localparam int MAX_CH_W = 4;

   typedef enum logic [1:0] {
      MANUAL = 2'b00,
      STEP   = 2'b01,
      AUTO   = 2'b10
   } mode_t;

   // Returns the next enabled channel strictly above cur, wrapping at nch;
   // returns cur itself when no other channel is enabled.
   function automatic int next_enabled(input logic [MAX_NCH-1:0] mask,
                                       input int cur,
                                       input int nch);
      int   idx;
      int   res;
      logic found;
      res   = cur;
      found = 1'b0;
      for (int i = 1; i < MAX_NCH; i++) begin
         idx = cur + i;
         if (idx >= nch) idx = idx - nch;
         if (!found && (i < nch) && mask[idx[MAX_CH_W-1:0]]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/debug_monitor_rise.sv
// Registered rising-edge detector: pulse is high in the cycle where 'in' is high
// and was low on the previous clock.
module rise_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic in,
   output logic pulse
);

   logic prev_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) prev_q <= 1'b0;
      else       prev_q <= in;
   end

   assign pulse = in & ~prev_q;

endmodule

// File: rtl/debug_monitor.sv
// Debug channel monitor: picks one of NCH packed channel words (manual, stepped or
// auto-rotating), registers it for display with freeze and leading-zero blanking.
module debug_monitor
   import debug_monitor_pkg::*;
#(
   parameter int NCH      = 8,
   parameter int W        = 16,
   parameter int PRESCALE = 50_000_000
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NCH*W-1:0]         ch_data,
   input  logic [$clog2(NCH)-1:0]   sel,
   input  logic [1:0]               mode,
   input  logic                     step,
   input  logic                     freeze,
   input  logic [NCH-1:0]           en_mask,
   input  logic                     lz_en,
   output logic [W-1:0]             disp,
   output logic [W/4-1:0]           blank,
   output logic [$clog2(NCH)-1:0]   cur_ch,
   output logic                     frozen
);

   localparam int CH_W  = $clog2(NCH);
   localparam int NIB   = W / 4;
   localparam int CNT_W = $clog2(PRESCALE);

   localparam logic [CH_W:0]    NCH_EXT = (CH_W+1)'(NCH);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(PRESCALE - 1);

   logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
   logic [W-1:0]     disp_q, disp_d;
   logic             frozen_q, frozen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             step_pulse;
   logic             freeze_pulse;
   mode_t            mode_eff;
   logic [CH_W-1:0]  sel_clamped;
   logic [CH_W-1:0]  adv_ch;

   rise_detect u_step_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .in    (step),
      .pulse (step_pulse)
   );

   rise_detect u_freeze_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .in    (freeze),
      .pulse (freeze_pulse)
   );

   // Mode 2'b11 is folded into MANUAL.
   always_comb begin
      case (mode)
         2'b01:   mode_eff = STEP;
         2'b10:   mode_eff = AUTO;
         default: mode_eff = MANUAL;
      endcase
   end

   assign sel_clamped = ({1'b0, sel} >= NCH_EXT) ? LAST_CH : sel;
   assign adv_ch      = CH_W'(next_enabled(MAX_NCH'(en_mask), int'(cur_ch_q), NCH));

   // The prescale counter only runs in AUTO, so any mode change restarts it from zero.
   always_comb begin
      cur_ch_d = cur_ch_q;
      cnt_d    = '0;
      case (mode_eff)
         STEP: begin
            if (step_pulse) cur_ch_d = adv_ch;
         end
         AUTO: begin
            if (cnt_q == CNT_TC) begin
               cur_ch_d = adv_ch;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: cur_ch_d = sel_clamped;
      endcase
   end

   always_comb begin
      frozen_d = freeze_pulse | (frozen_q & freeze);
      disp_d   = frozen_d ? disp_q : ch_data[int'(cur_ch_q) * W +: W];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cur_ch_q <= '0;
         disp_q   <= '0;
         frozen_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         cur_ch_q <= cur_ch_d;
         disp_q   <= disp_d;
         frozen_q <= frozen_d;
         cnt_q    <= cnt_d;
      end
   end

   // blank[i] marks nibble i as part of the leading-zero run; nibble 0 always shows.
   always_comb begin
      logic zero_run;
      blank    = '0;
      zero_run = 1'b1;
      for (int i = NIB - 1; i >= 1; i--) begin
         zero_run = zero_run & (disp_q[4*i +: 4] == 4'h0);
         blank[i] = lz_en & zero_run;
      end
   end

   assign disp   = disp_q;
   assign cur_ch = cur_ch_q;
   assign frozen = frozen_q;

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor (NCH=8, W=16, PRESCALE=4): a MANUAL vector table
// plus hand-written sequences for stepping, auto rotation, freeze and reset.
module tb_debug_monitor;

   localparam int NCH      = 8;
   localparam int W        = 16;
   localparam int PRESCALE = 4;

   logic             Clk;
   logic             Reset;
   logic [NCH*W-1:0] ch_data;
   logic [2:0]       sel;
   logic [1:0]       mode;
   logic             step;
   logic             freeze;
   logic [NCH-1:0]   en_mask;
   logic             lz_en;
   logic [W-1:0]     disp;
   logic [W/4-1:0]   blank;
   logic [2:0]       cur_ch;
   logic             frozen;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [2:0]  sel;
      logic        lz;
      logic [15:0] exp_disp;
      logic [3:0]  exp_blank;
   } vec_t;

   vec_t vecs[9];

   debug_monitor #(
      .NCH      (NCH),
      .W        (W),
      .PRESCALE (PRESCALE)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .ch_data (ch_data),
      .sel     (sel),
      .mode    (mode),
      .step    (step),
      .freeze  (freeze),
      .en_mask (en_mask),
      .lz_en   (lz_en),
      .disp    (disp),
      .blank   (blank),
      .cur_ch  (cur_ch),
      .frozen  (frozen)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_ch(input int k, input logic [15:0] val);
      ch_data[k*W +: W] = val;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      vecs[0] = '{3'd3, 1'b1, 16'h00A5, 4'b1100};
      vecs[1] = '{3'd0, 1'b1, 16'h0000, 4'b1110};
      vecs[2] = '{3'd1, 1'b1, 16'h000F, 4'b1110};
      vecs[3] = '{3'd2, 1'b1, 16'h0F00, 4'b1000};
      vecs[4] = '{3'd4, 1'b1, 16'h1234, 4'b0000};
      vecs[5] = '{3'd5, 1'b0, 16'hF000, 4'b0000};
      vecs[6] = '{3'd6, 1'b1, 16'h0001, 4'b1110};
      vecs[7] = '{3'd6, 1'b0, 16'h0001, 4'b0000};
      vecs[8] = '{3'd7, 1'b1, 16'hBEEF, 4'b0000};

      ch_data = '0;
      set_ch(0, 16'h0000);
      set_ch(1, 16'h000F);
      set_ch(2, 16'h0F00);
      set_ch(3, 16'h00A5);
      set_ch(4, 16'h1234);
      set_ch(5, 16'hF000);
      set_ch(6, 16'h0001);
      set_ch(7, 16'hBEEF);
      sel     = 3'd0;
      mode    = 2'b00;
      step    = 1'b0;
      freeze  = 1'b0;
      en_mask = 8'hFF;
      lz_en   = 1'b0;

      // Reset state, before and across a clock edge
      Reset = 1'b1;
      #2;
      check("rst_cur", 32'(cur_ch), 32'd0);
      check("rst_disp", 32'(disp), 32'h0);
      check("rst_frozen", 32'(frozen), 32'd0);
      tick();
      check("rst_edge_disp", 32'(disp), 32'h0);
      Reset = 1'b0;
      tick();
      check("post_rst_cur", 32'(cur_ch), 32'd0);

      // Test 1: MANUAL latency on channel 3
      lz_en = 1'b1;
      sel   = 3'd3;
      tick();
      check("t1_cur_1cyc", 32'(cur_ch), 32'd3);
      check("t1_disp_not_yet", 32'(disp), 32'h0000);
      tick();
      check("t1_disp_2cyc", 32'(disp), 32'h00A5);
      check("t1_blank", 32'(blank), 32'b1100);

      // MANUAL vector table
      for (int v = 0; v < 9; v++) begin
         sel   = vecs[v].sel;
         lz_en = vecs[v].lz;
         tick();
         check($sformatf("vec%0d_cur", v), 32'(cur_ch), 32'(vecs[v].sel));
         tick();
         check($sformatf("vec%0d_disp", v), 32'(disp), 32'(vecs[v].exp_disp));
         check($sformatf("vec%0d_blank", v), 32'(blank), 32'(vecs[v].exp_blank));
      end

      // Mode 2'b11 behaves as MANUAL
      mode = 2'b11;
      sel  = 3'd5;
      tick();
      check("mode11_cur", 32'(cur_ch), 32'd5);

      // Test 2: STEP with skip and wrap
      mode    = 2'b00;
      sel     = 3'd2;
      en_mask = 8'b1000_0101;
      tick();
      check("t2_start", 32'(cur_ch), 32'd2);
      mode = 2'b01;
      tick();
      check("t2_enter_step", 32'(cur_ch), 32'd2);
      step = 1'b1; tick();
      check("t2_step1", 32'(cur_ch), 32'd7);
      step = 1'b0; tick();
      check("t2_low1", 32'(cur_ch), 32'd7);
      step = 1'b1; tick();
      check("t2_step2", 32'(cur_ch), 32'd0);
      step = 1'b0; tick();
      step = 1'b1; tick();
      check("t2_step3", 32'(cur_ch), 32'd2);
      step = 1'b0; tick();
      step = 1'b1; tick();
      check("t2_step4", 32'(cur_ch), 32'd7);
      tick(); tick(); tick();
      check("t2_held_high", 32'(cur_ch), 32'd7);
      step = 1'b0; tick();

      // A step edge taken in MANUAL is not replayed in STEP
      mode = 2'b00;
      sel  = 3'd7;
      tick();
      step = 1'b1; tick(); tick();
      mode = 2'b01;
      tick(); tick();
      check("t2_no_queued", 32'(cur_ch), 32'd7);
      step = 1'b0; tick();

      // Test 3: AUTO rotation with PRESCALE=4
      mode    = 2'b00;
      sel     = 3'd6;
      en_mask = 8'hFF;
      tick();
      check("t3_start", 32'(cur_ch), 32'd6);
      mode = 2'b10;
      tick(); tick(); tick();
      check("t3_cyc3", 32'(cur_ch), 32'd6);
      tick();
      check("t3_cyc4", 32'(cur_ch), 32'd7);
      tick(); tick(); tick();
      check("t3_cyc7", 32'(cur_ch), 32'd7);
      tick();
      check("t3_cyc8", 32'(cur_ch), 32'd0);
      tick(); tick();
      mode = 2'b00;
      sel  = 3'd0;
      tick();
      mode = 2'b10;
      tick(); tick(); tick();
      check("t3_cleared_cyc3", 32'(cur_ch), 32'd0);
      tick();
      check("t3_cleared_cyc4", 32'(cur_ch), 32'd1);

      // Test 4: freeze while stepping
      mode = 2'b00;
      sel  = 3'd4;
      tick(); tick();
      check("t4_disp_pre", 32'(disp), 32'h1234);
      mode = 2'b01;
      tick();
      freeze = 1'b1;
      tick();
      check("t4_frozen_edge", 32'(frozen), 32'd1);
      check("t4_disp_edge", 32'(disp), 32'h1234);
      set_ch(4, 16'hFFFF);
      set_ch(5, 16'hFFFF);
      step = 1'b1; tick();
      check("t4_cur_adv", 32'(cur_ch), 32'd5);
      check("t4_disp_hold", 32'(disp), 32'h1234);
      step = 1'b0; tick();
      check("t4_disp_hold2", 32'(disp), 32'h1234);
      check("t4_frozen_hold", 32'(frozen), 32'd1);
      freeze = 1'b0;
      tick();
      check("t4_unfrozen", 32'(frozen), 32'd0);
      check("t4_disp_new", 32'(disp), 32'hFFFF);

      // Test 5: asynchronous reset in AUTO while frozen
      set_ch(0, 16'hC0DE);
      lz_en  = 1'b0;
      mode   = 2'b10;
      freeze = 1'b1;
      tick(); tick();
      check("t5_pre_frozen", 32'(frozen), 32'd1);
      check("t5_pre_cur", 32'(cur_ch), 32'd5);
      #3;
      Reset = 1'b1;
      #1;
      check("t5_async_cur", 32'(cur_ch), 32'd0);
      check("t5_async_disp", 32'(disp), 32'h0);
      check("t5_async_frozen", 32'(frozen), 32'd0);
      check("t5_async_blank", 32'(blank), 32'h0);
      tick();
      check("t5_hold_disp", 32'(disp), 32'h0);
      Reset  = 1'b0;
      freeze = 1'b0;
      mode   = 2'b00;
      sel    = 3'd7;
      tick();
      check("t5_first_cur", 32'(cur_ch), 32'd7);
      check("t5_first_disp", 32'(disp), 32'hC0DE);
      tick();
      check("t5_second_disp", 32'(disp), 32'hBEEF);

      // Test 6: empty mask and self-only mask hold the channel
      mode    = 2'b01;
      en_mask = 8'h00;
      for (int p = 0; p < 10; p++) begin
         step = 1'b1; tick();
         check($sformatf("t6_step%0d", p), 32'(cur_ch), 32'd7);
         step = 1'b0; tick();
      end
      mode = 2'b10;
      for (int c = 0; c < 2 * PRESCALE; c++) tick();
      check("t6_auto_empty", 32'(cur_ch), 32'd7);
      en_mask = 8'h80;
      for (int c = 0; c < 2 * PRESCALE; c++) tick();
      check("t6_auto_self", 32'(cur_ch), 32'd7);
      en_mask = 8'h81;
      for (int c = 0; c < PRESCALE; c++) tick();
      check("t6_auto_wrap", 32'(cur_ch), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
